// File: rtl/axi_rd_pkg.sv
// Shared AXI read-side definitions: burst encodings, response codes and the
// slave FSM state type. Imported by the burst address generator and the
// read-only memory slave.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address generator.
// Ports:
//   addr      - address of the current beat (already aligned to size)
//   len       - ARLEN/AWLEN (beats-1)
//   size      - log2 bytes per beat
//   burst     - FIXED / INCR / WRAP (RSVD holds the address)
//   next_addr - address of the following beat
module axi_burst_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        len,
  input  logic [2:0]        size,
  input  burst_t            burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size;
    // Wrap window is (len+1) beats wide; mask selects the offset inside it.
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = addr + step;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_slave_mem.sv
// Read-only AXI4 memory slave model with programmable first-beat latency.
// One burst is serviced at a time; FIXED/INCR/WRAP supported; illegal or
// out-of-range beats return SLVERR with zero data. A backdoor port preloads
// the memory.
// Ports:
//   G_clk, G_reset        - clock, synchronous active-high reset
//   AR*                   - read address channel (slave side)
//   R*                    - read data channel (slave side)
//   bd_wr_en/idx/data     - backdoor word write
//   err_count             - saturating count of accepted SLVERR beats
// Handshakes: a transfer occurs on a rising edge where VALID and READY are
// both high; RVALID with its RDATA/RRESP/RLAST is held stable until accepted.
module axi_rd_slave_mem
  import axi_rd_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 LATENCY   = 2
) (
  input  logic                         G_clk,
  input  logic                         G_reset,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic [3:0]                   ARLEN,
  input  logic [2:0]                   ARSIZE,
  input  logic [1:0]                   ARBURST,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RLAST,
  output logic                         RVALID,
  input  logic                         RREADY,
  input  logic                         bd_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_wr_idx,
  input  logic [DATA_W-1:0]            bd_wr_data,
  output logic [7:0]                   err_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;      // address of the next beat to load
  logic [3:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  burst_t            burst_q, burst_d;
  logic              req_err_q, req_err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        beat_idx_q, beat_idx_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        err_count_q, err_count_d;

  logic              ar_fire;
  logic [ADDR_W-1:0] ar_align;
  logic              ar_err;
  logic              from_ar;
  logic [ADDR_W-1:0] src_addr;
  logic [3:0]        src_len;
  logic [2:0]        src_size;
  burst_t            src_burst;
  logic              src_err;
  logic [3:0]        src_idx;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] word;
  logic              beat_err;
  logic              load;

  always_comb begin
    ar_fire  = ARVALID & arready_q;
    ar_align = ARADDR & ~((ADDR_W'(1) << ARSIZE) - ADDR_W'(1));
    ar_err   = (ARBURST == BURST_RSVD) | (ARSIZE > 3'd2) |
               ((ARBURST == BURST_WRAP) & ~wrap_len_ok(ARLEN));

    // In IDLE the first beat (LATENCY==1) is loaded straight from the AR
    // channel; otherwise from the latched request.
    from_ar   = (state_q == IDLE);
    src_addr  = from_ar ? ar_align         : addr_q;
    src_len   = from_ar ? ARLEN            : len_q;
    src_size  = from_ar ? ARSIZE           : size_q;
    src_burst = from_ar ? burst_t'(ARBURST) : burst_q;
    src_err   = from_ar ? ar_err           : req_err_q;
    src_idx   = from_ar ? 4'd0             : beat_idx_q;

    word     = (src_addr - BASE_ADDR) >> 2;
    beat_err = src_err | (src_addr < BASE_ADDR) | (word >= ADDR_W'(MEM_DEPTH));
  end

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (src_addr),
    .len       (src_len),
    .size      (src_size),
    .burst     (src_burst),
    .next_addr (next_addr)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    req_err_d   = req_err_q;
    cnt_d       = cnt_q;
    beat_idx_d  = beat_idx_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    err_count_d = err_count_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          arready_d  = 1'b0;
          addr_d     = ar_align;
          len_d      = ARLEN;
          size_d     = ARSIZE;
          burst_d    = burst_t'(ARBURST);
          req_err_d  = ar_err;
          beat_idx_d = 4'd0;
          if (LATENCY == 1) begin
            load    = 1'b1;
            state_d = BURST;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          load    = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (rvalid_q & RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory is read combinationally before this edge's backdoor write
    // lands, so a same-word collision returns the old contents.
    if (load) begin
      rvalid_d   = 1'b1;
      rdata_d    = beat_err ? '0 : mem[word[IDX_W-1:0]];
      rresp_d    = beat_err ? RESP_SLVERR : RESP_OKAY;
      rlast_d    = (src_idx == src_len);
      addr_d     = next_addr;
      beat_idx_d = src_idx + 4'd1;
    end

    if (rvalid_q & RREADY & (rresp_q == RESP_SLVERR) & (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge G_clk) begin
    if (G_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BURST_FIXED;
      req_err_q   <= 1'b0;
      cnt_q       <= '0;
      beat_idx_q  <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      req_err_q   <= req_err_d;
      cnt_q       <= cnt_d;
      beat_idx_q  <= beat_idx_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      err_count_q <= err_count_d;
    end
  end

  // Contents survive reset.
  always_ff @(posedge G_clk) begin
    if (bd_wr_en && (32'(bd_wr_idx) < MEM_DEPTH))
      mem[bd_wr_idx] <= bd_wr_data;
  end

  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RLAST     = rlast_q;
  assign RRESP     = rresp_q;
  assign RDATA     = rdata_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Directed bench for axi_rd_slave_mem (LATENCY=2, MEM_DEPTH=256, BASE=0).
module tb_axi_rd_slave_mem;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_DEPTH = 256;
  localparam int LATENCY = 2;

  logic              clk;
  logic              G_reset;
  logic [ADDR_W-1:0] ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              bd_wr_en;
  logic [7:0]        bd_wr_idx;
  logic [DATA_W-1:0] bd_wr_data;
  logic [7:0]        err_count;

  axi_rd_slave_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
    .BASE_ADDR(32'h0000_0000), .LATENCY(LATENCY)
  ) dut (
    .G_clk(clk), .G_reset(G_reset),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .bd_wr_en(bd_wr_en), .bd_wr_idx(bd_wr_idx), .bd_wr_data(bd_wr_data),
    .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int exp_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        exp_resp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic [1:0] r);
    exp_q.push_back(d);
    exp_resp_q.push_back(r);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic bd_write(input int idx, input logic [DATA_W-1:0] d);
    bd_wr_en = 1'b1;
    bd_wr_idx = 8'(idx);
    bd_wr_data = d;
    @(negedge clk);
    bd_wr_en = 1'b0;
  endtask

  // Returns at the negedge right after the handshake cycle.
  task automatic issue_ar(input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int cnt = 0;
    while (!ARREADY && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!ARREADY) check_val("arready_timeout", 32'(ARREADY), 32'd1);
    ARADDR = a;
    ARLEN = len;
    ARSIZE = size;
    ARBURST = burst;
    ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    check_val("arready_drop", 32'(ARREADY), 32'd0);
  endtask

  // Collects n beats against the expected queues; optionally stalls one beat.
  task automatic collect(input int n, input int stall_beat, input int stall_cycles);
    for (int i = 0; i < n; i++) begin
      int cnt;
      logic [DATA_W-1:0] d, ed;
      logic [1:0] r, er;
      logic l;
      cnt = 0;
      if (i > 0) check_val("no_bubble", 32'(RVALID), 32'd1);
      while (!RVALID && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      if (!RVALID) begin
        check_val("rvalid_timeout", 32'(RVALID), 32'd1);
        return;
      end
      if (i == stall_beat) begin
        RREADY = 1'b0;
        d = RDATA;
        r = RRESP;
        l = RLAST;
        repeat (stall_cycles) begin
          @(negedge clk);
          check_val("stall_valid", 32'(RVALID), 32'd1);
          check_val("stall_data", RDATA, d);
          check_val("stall_resp", 32'(RRESP), 32'(r));
          check_val("stall_last", 32'(RLAST), 32'(l));
        end
        RREADY = 1'b1;
      end
      if (exp_q.size() == 0) begin
        check_val("exp_queue_empty", 32'(exp_q.size()), 32'd1);
        return;
      end
      ed = exp_q.pop_front();
      er = exp_resp_q.pop_front();
      check_val($sformatf("beat%0d_data", i), RDATA, ed);
      check_val($sformatf("beat%0d_resp", i), 32'(RRESP), 32'(er));
      check_val($sformatf("beat%0d_last", i), 32'(RLAST), (i == n - 1) ? 32'd1 : 32'd0);
      if (er == 2'b10) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      @(negedge clk);
    end
    check_val("end_rvalid", 32'(RVALID), 32'd0);
    check_val("end_arready", 32'(ARREADY), 32'd1);
    check_val("err_count", 32'(err_count), 32'(exp_err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    G_reset = 1'b1;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b1;
    bd_wr_en = 1'b0; bd_wr_idx = '0; bd_wr_data = '0;
    repeat (3) @(negedge clk);

    check_val("rst_arready", 32'(ARREADY), 32'd0);
    check_val("rst_rvalid", 32'(RVALID), 32'd0);
    check_val("rst_rlast", 32'(RLAST), 32'd0);
    check_val("rst_rresp", 32'(RRESP), 32'd0);
    check_val("rst_rdata", RDATA, 32'd0);
    check_val("rst_err_count", 32'(err_count), 32'd0);
    G_reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_arready", 32'(ARREADY), 32'd1);

    // 1. INCR read with latency check
    for (int k = 0; k < 4; k++) bd_write(k, 32'hA0A0_0000 + 32'(k));
    issue_ar(32'h0, 4'd3, 3'd2, 2'd1);
    check_val("latency_early", 32'(RVALID), 32'd0);
    @(negedge clk);
    check_val("latency_on", 32'(RVALID), 32'd1);
    for (int k = 0; k < 4; k++) push_beat(32'hA0A0_0000 + 32'(k), 2'b00);
    collect(4, -1, 0);

    // 2. WRAP: words 2,3,0,1 ; then illegal WRAP length (3 beats)
    push_beat(32'hA0A0_0002, 2'b00);
    push_beat(32'hA0A0_0003, 2'b00);
    push_beat(32'hA0A0_0000, 2'b00);
    push_beat(32'hA0A0_0001, 2'b00);
    issue_ar(32'h8, 4'd3, 3'd2, 2'd2);
    collect(4, -1, 0);
    for (int k = 0; k < 3; k++) push_beat(32'h0, 2'b10);
    issue_ar(32'h8, 4'd2, 3'd2, 2'd2);
    collect(3, -1, 0);                       // err_count -> 3

    // 3. Backpressure on beat 2 for 3 cycles
    for (int k = 0; k < 4; k++) push_beat(32'hA0A0_0000 + 32'(k), 2'b00);
    issue_ar(32'h0, 4'd3, 3'd2, 2'd1);
    collect(4, 1, 3);

    // 4. Range edge: words 254,255 OK, 256,257 SLVERR
    bd_write(254, 32'hB000_00FE);
    bd_write(255, 32'hB000_00FF);
    push_beat(32'hB000_00FE, 2'b00);
    push_beat(32'hB000_00FF, 2'b00);
    push_beat(32'h0, 2'b10);
    push_beat(32'h0, 2'b10);
    issue_ar(32'h3F8, 4'd3, 3'd2, 2'd1);
    collect(4, -1, 0);                       // err_count -> 5

    // 5. FIXED, illegal size, reserved burst
    bd_write(4, 32'hC000_0004);
    for (int k = 0; k < 3; k++) push_beat(32'hC000_0004, 2'b00);
    issue_ar(32'h10, 4'd2, 3'd2, 2'd0);
    collect(3, -1, 0);
    for (int k = 0; k < 2; k++) push_beat(32'h0, 2'b10);
    issue_ar(32'h0, 4'd1, 3'd3, 2'd1);
    collect(2, -1, 0);                       // err_count -> 7
    for (int k = 0; k < 2; k++) push_beat(32'h0, 2'b10);
    issue_ar(32'h0, 4'd1, 3'd2, 2'd3);
    collect(2, -1, 0);                       // err_count -> 9

    // 6. Reset during beat 2 of 4
    issue_ar(32'h0, 4'd3, 3'd2, 2'd1);
    @(negedge clk);
    check_val("rb_beat0", RDATA, 32'hA0A0_0000);
    @(negedge clk);
    check_val("rb_beat1", RDATA, 32'hA0A0_0001);
    G_reset = 1'b1;
    @(negedge clk);
    check_val("midrst_rvalid", 32'(RVALID), 32'd0);
    check_val("midrst_arready", 32'(ARREADY), 32'd0);
    G_reset = 1'b0;
    exp_err = 0;
    @(negedge clk);
    check_val("rel_arready", 32'(ARREADY), 32'd1);
    check_val("rel_err_count", 32'(err_count), 32'd0);
    for (int k = 0; k < 4; k++) push_beat(32'hA0A0_0000 + 32'(k), 2'b00);
    issue_ar(32'h0, 4'd3, 3'd2, 2'd1);
    collect(4, -1, 0);

    // Backdoor write colliding with the first-beat load returns old data
    bd_write(5, 32'hD0D0_0001);
    issue_ar(32'h14, 4'd0, 3'd2, 2'd1);
    bd_wr_en = 1'b1;
    bd_wr_idx = 8'd5;
    bd_wr_data = 32'hD0D0_0002;
    @(negedge clk);
    bd_wr_en = 1'b0;
    push_beat(32'hD0D0_0001, 2'b00);
    collect(1, -1, 0);
    push_beat(32'hD0D0_0002, 2'b00);
    issue_ar(32'h14, 4'd0, 3'd2, 2'd1);
    collect(1, -1, 0);

    // err_count saturation: 256 SLVERR beats -> 255
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) push_beat(32'h0, 2'b10);
      issue_ar(32'h0, 4'd15, 3'd2, 2'd3);
      collect(16, -1, 0);
    end
    check_val("err_saturated", 32'(err_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_slave_mem.md
Name: axi_rd_slave_mem

Overview:
Read-only AXI4 memory slave model that sits directly downstream of the interconnect's M00/M01 read ports (ARADDR_Sx/ARVALID_Sx in, RDATA/RVALID/RLAST out).
- Accepts one burst at a time and returns beats after a programmable latency.
- Supports FIXED/INCR/WRAP bursts with RREADY backpressure.
- Flags out-of-range or illegal requests with SLVERR.
- A backdoor write port preloads contents for test.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 4-byte beats; ARSIZE > 2 is illegal)
MEM_DEPTH, 256, number of DATA_W words
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
LATENCY, 2, cycles from AR handshake to first RVALID; legal range 1..15

Ports:
G_clk  in  1  clock
G_reset  in  1  synchronous reset, active-high
ARADDR  in  ADDR_W  read address
ARLEN  in  4  beats-1
ARSIZE  in  3  log2 bytes/beat
ARBURST  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
ARVALID  in  1  address valid
ARREADY  out  1  address accepted
RDATA  out  DATA_W  read data
RRESP  out  2  0 OKAY, 2 SLVERR
RLAST  out  1  final beat
RVALID  out  1  data valid
RREADY  in  1  data accepted
bd_wr_en  in  1  backdoor write strobe
bd_wr_idx  in  $clog2(MEM_DEPTH)  backdoor word index
bd_wr_data  in  DATA_W  backdoor data
err_count  out  8  saturating count of SLVERR beats accepted

Behaviour:
Clock/reset: single clock G_clk. G_reset is synchronous and active-high.

Reset values: ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0, err_count=0. State goes to IDLE. Memory contents are not reset.

Registers: all outputs are registered.

State machine:
- IDLE: ARREADY=1.
  - On ARVALID&ARREADY: latch addr, len, size, burst. Compute req_err = (ARBURST==3) | (ARSIZE>2) | (WRAP & ARLEN not in {1,3,7,15}).
  - ARREADY drops the next cycle. Load the latency counter with LATENCY-1.
  - Go to WAIT; if LATENCY==1, go directly to BURST.
- WAIT: decrement the counter. At 0, load the first beat and go to BURST. RVALID is high exactly LATENCY cycles after the handshake cycle.
- BURST: RVALID=1 and outputs are held stable until RVALID&RREADY.
  - On an accepted non-last beat, load the next beat in the same cycle, so there is no bubble.
  - On an accepted last beat (RLAST=1): RVALID=0 and ARREADY=1 the next cycle (IDLE). There is no AR/R overlap.

Beat load:
- word = (addr - BASE_ADDR) >> 2.
- Beat error = req_err | (addr < BASE_ADDR) | (word >= MEM_DEPTH).
- On error: RDATA=0, RRESP=2. Otherwise RDATA=mem[word], RRESP=0.
- RLAST = (beat_cnt == len).

Address generation (start address aligned down to size):
- FIXED: address unchanged.
- INCR: addr + (1<<size), no 4 KB checks.
- WRAP: boundary = (len+1)<<size; next = (addr & ~(boundary-1)) | ((addr + (1<<size)) & (boundary-1)).

Backdoor:
- bd_wr_en writes mem[bd_wr_idx] at the clock edge; an out-of-range index is ignored.
- If a write and a beat load to the same word occur in the same cycle, the beat returns the old data (read-before-write).
- Writes during RVALID never alter the presented RDATA.

err_count: increments on each accepted beat with RRESP=2 and saturates at 255.

Reset mid-burst: the next cycle has RVALID=0 and the remaining beats are discarded. ARREADY=1 on the first cycle after G_reset falls.

Decomposition:
- Shared package axi_rd_pkg: burst enum (BURST_FIXED/INCR/WRAP/RSVD), resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), state enum {IDLE, WAIT, BURST}.
- Sub-module axi_burst_addr_gen: combinational next-address from (addr, len, size, burst). Reused by future write-side slave and master models.

Test Plan:
1. INCR read: backdoor mem[0..3]=A0..A3; AR 0x0 len3 size2 INCR; RREADY=1; LATENCY=2 → RVALID 2 cycles after handshake; A0,A1,A2,A3 on consecutive cycles; RLAST on beat 4; RRESP=0; ARREADY=1 the cycle after.
2. WRAP read: AR 0x8 len3 size2 WRAP → data from words 2,3,0,1; WRAP with len2 → 3 beats, all SLVERR, RDATA=0, err_count=3.
3. Backpressure: RREADY low for 3 cycles on beat 2 → RDATA/RLAST/RRESP stable throughout; beat 3 appears the cycle after RREADY rises.
4. Range edge: MEM_DEPTH=256; AR 0x3F8 len3 INCR → beats 0,1 OKAY (words 254,255); beats 2,3 SLVERR with data 0; err_count +2.
5. FIXED / illegal size: AR 0x10 len2 FIXED → mem[4] three times; ARSIZE=3 → all beats SLVERR; ARBURST=3 → all beats SLVERR.
6. Reset: assert G_reset during beat 2 of 4 → next cycle RVALID=0, ARREADY=0; after release ARREADY=1 and a new burst returns correct data. Backdoor write to the word being loaded in the same cycle → old data returned.
